reg_write_arbiter: RTL
======================

# reg_write_arbiter

Shares the single write port of the 8 x 8-bit register file between two requesters: requester 0 is ALU writeback and requester 1 is the load/host path. Each requester posts writes through a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drives registered WRITEREG/WRITEDATA/WRITEENABLE into the register file. An optional clear sequencer zeroes all registers on command.

## Interface
Parameters:
- DATA_WIDTH, 8, width of write data
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ0_VALID  in  1  requester 0 offers a write
- REQ0_REG  in  ADDR_WIDTH  requester 0 target register
- REQ0_DATA  in  DATA_WIDTH  requester 0 write data
- REQ0_READY  out  1  requester 0 buffer can accept
- REQ1_VALID, REQ1_REG, REQ1_DATA, REQ1_READY  same as requester 0, for requester 1
- CLEAR  in  1  request to zero all registers (sampled on edge)
- BUSY  out  1  clear pending or in progress
- GRANT  out  2  one-hot source of the current write-port cycle; 00 means idle or clear
- WRITEREG  out  ADDR_WIDTH  to register file
- WRITEDATA  out  DATA_WIDTH  to register file
- WRITEENABLE  out  1  to register file

## Operation
- Handshake: transfer occurs at an edge where VALID && READY. The buffer captures REG/DATA. READY = !buf_full && !clear_pending.
- Arbitration runs at each edge in IDLE. The eligible candidates are the full buffers.
  - One full: that buffer is granted.
  - Both full: the buffer named by the RR pointer is granted, and the pointer then moves to the other requester.
  - A single grant also sets the pointer to the other requester.
  - At the granting edge the output registers load REG/DATA, WRITEENABLE=1, GRANT is set one-hot, and the granted buffer empties.
- No grant at an edge: WRITEENABLE=0, GRANT=00, WRITEREG/WRITEDATA hold their last values.
- Ordering: writes from one requester reach the port in acceptance order. Same-register writes from both requesters resolve in grant order, so the last granted value persists in the register file.
- Clear FSM has states IDLE, DRAIN and SWEEP.
  - CLEAR=1 at an edge in IDLE sets clear_pending and enters DRAIN. Both READY deassert.
  - DRAIN: arbitration continues until both buffers are empty. At the first edge with both buffers empty, the FSM enters SWEEP with count=0.
  - SWEEP: each edge outputs WRITEREG=count, WRITEDATA=0, WRITEENABLE=1, GRANT=00, then count+1. After the write of NUM_REGS-1, the FSM returns to IDLE and clear_pending drops.
  - CLEAR asserted in DRAIN or SWEEP is ignored, with no restart and no queueing.
- BUSY = (state != IDLE).
- Reset, whether idle or mid-operation:
  - Buffers empty, RR pointer = 0, state IDLE, count = 0.
  - WRITEENABLE=0, WRITEREG=0, WRITEDATA=0, GRANT=00, BUSY=0.
  - REQ0_READY=REQ1_READY=1.
  - Any partial sweep is abandoned.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Latency: accepted at edge k gives WRITEENABLE high during the cycle after edge k+1 at the earliest. The register file commits at edge k+2.
- Per-requester throughput is 1 write per 2 cycles, because READY returns only after the buffer drains. Aggregate port throughput is 1 write per cycle.
- WRITEENABLE is never high for two cycles from the same buffer entry.
- Worst-case wait for a full buffer is 1 extra cycle (round robin).
- A clear from IDLE with empty buffers takes NUM_REGS consecutive WRITEENABLE cycles starting the cycle after the CLEAR edge. BUSY is high for NUM_REGS cycles.

## Configuration
- REGARB_CLEAR_EN defined: clear FSM, counter, CLEAR and BUSY behave as above.
- REGARB_CLEAR_EN undefined: no FSM or counter logic. CLEAR is ignored and BUSY is tied 0. READY = !buf_full. Arbitration is otherwise identical.

## Test plan
- Single write: REQ0 REG=2 DATA=95 accepted at edge k. WRITEENABLE=1, WRITEREG=2, WRITEDATA=95, GRANT=01 in cycle k+1 only. REQ0_READY is low between edges k and k+1.
- Contention: both buffers loaded at the same edge, REQ0 REG=1 DATA=28 and REQ1 REG=1 DATA=6, pointer=0. Grants are 01 then 10 on consecutive cycles. Register 1 holds 6 and the pointer ends at 0.
- Sustained both: both requesters hold VALID for 8 writes each. WRITEENABLE is high every cycle, GRANT alternates 01/10, and no write is lost or duplicated.
- Clear with pending: REQ1 buffer full (REG=4, DATA=15), then CLEAR. The REG=4 write issues first, then writes of 0 to registers 0..7 in order. BUSY is high throughout and both READY stay low until the cycle after the last sweep write.
- Reset mid-sweep: RESET low after the write to register 3. Outputs go to 0 immediately, and BUSY=0, READY=1. Registers 4..7 are not written by the arbiter afterward.
- Build without REGARB_CLEAR_EN: pulse CLEAR. There is no WRITEENABLE activity and BUSY stays 0.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between the two requesters, the clear control and the register file.
interface reg_write_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  REQ0_VALID;
   logic [ADDR_WIDTH-1:0] REQ0_REG;
   logic [DATA_WIDTH-1:0] REQ0_DATA;
   logic                  REQ0_READY;
   logic                  REQ1_VALID;
   logic [ADDR_WIDTH-1:0] REQ1_REG;
   logic [DATA_WIDTH-1:0] REQ1_DATA;
   logic                  REQ1_READY;
   logic                  CLEAR;
   logic                  BUSY;
   logic [1:0]            GRANT;
   logic [ADDR_WIDTH-1:0] WRITEREG;
   logic [DATA_WIDTH-1:0] WRITEDATA;
   logic                  WRITEENABLE;

   modport master (
      output REQ0_VALID, REQ0_REG, REQ0_DATA,
      output REQ1_VALID, REQ1_REG, REQ1_DATA,
      output CLEAR,
      input  REQ0_READY, REQ1_READY, BUSY, GRANT,
      input  WRITEREG, WRITEDATA, WRITEENABLE
   );

   modport slave (
      input  REQ0_VALID, REQ0_REG, REQ0_DATA,
      input  REQ1_VALID, REQ1_REG, REQ1_DATA,
      input  CLEAR,
      output REQ0_READY, REQ1_READY, BUSY, GRANT,
      output WRITEREG, WRITEDATA, WRITEENABLE
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two one-entry buffered requesters.
// Define REGARB_CLEAR_EN to build the clear sequencer (CLEAR/BUSY); otherwise CLEAR is ignored.
module reg_write_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic               CLK,
   input  logic               RESET,
   reg_write_arbiter_if.slave bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam int CNT_W    = ADDR_WIDTH + 1;

   logic                  full0, full1;
   logic [ADDR_WIDTH-1:0] buf_reg0, buf_reg1;
   logic [DATA_WIDTH-1:0] buf_data0, buf_data1;
   logic                  rr_ptr;
   logic                  ready0, ready1, accept0, accept1, grant0, grant1;
   logic                  arb_en, sweep_write, clear_pending;
   logic [ADDR_WIDTH-1:0] sweep_reg;

   logic                  we_q, we_next;
   logic [1:0]            grant_q, grant_next;
   logic [ADDR_WIDTH-1:0] wreg_q, wreg_next;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_next;

   assign ready0  = !full0 && !clear_pending;
   assign ready1  = !full1 && !clear_pending;
   assign accept0 = bus.REQ0_VALID && ready0;
   assign accept1 = bus.REQ1_VALID && ready1;

   // A lone full buffer always wins; on contention the pointer picks.
   assign grant0 = arb_en && full0 && (!full1 || !rr_ptr);
   assign grant1 = arb_en && full1 && (!full0 ||  rr_ptr);

   always_comb begin
      we_next    = 1'b0;
      grant_next = 2'b00;
      wreg_next  = wreg_q;
      wdata_next = wdata_q;
      if (grant0) begin
         we_next    = 1'b1;
         grant_next = 2'b01;
         wreg_next  = buf_reg0;
         wdata_next = buf_data0;
      end else if (grant1) begin
         we_next    = 1'b1;
         grant_next = 2'b10;
         wreg_next  = buf_reg1;
         wdata_next = buf_data1;
      end else if (sweep_write) begin
         we_next    = 1'b1;
         wreg_next  = sweep_reg;
         wdata_next = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         full0     <= 1'b0;
         full1     <= 1'b0;
         buf_reg0  <= '0;
         buf_reg1  <= '0;
         buf_data0 <= '0;
         buf_data1 <= '0;
         rr_ptr    <= 1'b0;
         we_q      <= 1'b0;
         grant_q   <= 2'b00;
         wreg_q    <= '0;
         wdata_q   <= '0;
      end else begin
         if (accept0) begin
            full0     <= 1'b1;
            buf_reg0  <= bus.REQ0_REG;
            buf_data0 <= bus.REQ0_DATA;
         end else if (grant0) begin
            full0 <= 1'b0;
         end
         if (accept1) begin
            full1     <= 1'b1;
            buf_reg1  <= bus.REQ1_REG;
            buf_data1 <= bus.REQ1_DATA;
         end else if (grant1) begin
            full1 <= 1'b0;
         end
         if (grant0) begin
            rr_ptr <= 1'b1;
         end else if (grant1) begin
            rr_ptr <= 1'b0;
         end
         we_q    <= we_next;
         grant_q <= grant_next;
         wreg_q  <= wreg_next;
         wdata_q <= wdata_next;
      end
   end

`ifdef REGARB_CLEAR_EN
   typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} clear_state_t;

   clear_state_t     state, state_next;
   logic [CNT_W-1:0] count, count_next;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Register 0 issues on the edge the buffers are seen empty, so the sweep is back to back;
   // count then names the register on the port and SWEEP lingers one cycle past the last write.
   always_comb begin
      state_next  = state;
      count_next  = count;
      arb_en      = 1'b1;
      sweep_write = 1'b0;
      sweep_reg   = count[ADDR_WIDTH-1:0];
      unique case (state)
         IDLE: begin
            if (bus.CLEAR) begin
               if (!full0 && !full1) begin
                  sweep_write = 1'b1;
                  sweep_reg   = '0;
                  count_next  = CNT_W'(1);
                  state_next  = SWEEP;
               end else begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!full0 && !full1) begin
               sweep_write = 1'b1;
               sweep_reg   = '0;
               count_next  = CNT_W'(1);
               state_next  = SWEEP;
            end
         end
         SWEEP: begin
            arb_en = 1'b0;
            if (count == CNT_W'(NUM_REGS)) begin
               count_next = '0;
               state_next = IDLE;
            end else begin
               sweep_write = 1'b1;
               count_next  = count + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   assign clear_pending = (state != IDLE);
   assign bus.BUSY      = clear_pending;
`else
   assign arb_en        = 1'b1;
   assign sweep_write   = 1'b0;
   assign sweep_reg     = '0;
   assign clear_pending = 1'b0;
   assign bus.BUSY      = 1'b0;
`endif

   assign bus.REQ0_READY  = ready0;
   assign bus.REQ1_READY  = ready1;
   assign bus.GRANT       = grant_q;
   assign bus.WRITEREG    = wreg_q;
   assign bus.WRITEDATA   = wdata_q;
   assign bus.WRITEENABLE = we_q;
endmodule
